// File: rtl/code_loader_if.sv
// ---------------------------------------------------------------------------
// code_loader_if : byte-stream and code-memory write bus for code_loader.
//   master : stream source / observer (drives start, byte_in, byte_valid)
//   slave  : loader (drives byte_ready, memory write port and status)
//   start        begin a load session
//   byte_in      stream byte, qualified by byte_valid / byte_ready
//   write_select memory write address, mem_data write data, mem_select strobe
//   busy/done/error/words_loaded session status
// ---------------------------------------------------------------------------
interface code_loader_if #(
   parameter int unsigned ADDR_W = 6
);
   logic              start;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic [ADDR_W-1:0] write_select;
   logic [15:0]       mem_data;
   logic              mem_select;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   words_loaded;

   modport master (
      output start, byte_in, byte_valid,
      input  byte_ready, write_select, mem_data, mem_select,
             busy, done, error, words_loaded
   );

   modport slave (
      input  start, byte_in, byte_valid,
      output byte_ready, write_select, mem_data, mem_select,
             busy, done, error, words_loaded
   );
endinterface

// File: rtl/code_loader.sv
// ---------------------------------------------------------------------------
// code_loader : fills the code memory from a length-prefixed big-endian byte
// stream (N, then N words as hi/lo byte pairs) and drives its write port.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : code_loader_if.slave (stream handshake, memory write, status)
// Optional feature macro: CODE_LOADER_CHECKSUM_EN
//   defined   -> a trailing XOR checksum byte is checked before DONE
//   undefined -> the last write goes straight to DONE
// ---------------------------------------------------------------------------
module code_loader #(
   parameter int unsigned ADDR_W = 6
) (
   input logic          clk,
   input logic          rst_n,
   code_loader_if.slave bus
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned DEPTH = 32'd1 << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_HI, S_LO, S_WR, S_CHK, S_DONE, S_ERR
   } state_t;

   state_t            state_q;
   logic [7:0]        len_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W-1:0] wsel_q;
   logic [15:0]       data_q;
   logic              strobe_q;
   logic              ready_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
`ifdef CODE_LOADER_CHECKSUM_EN
   logic [7:0]        csum_q;
`endif

   logic xfer;
   logic len_bad;
   logic last_word;

   // byte handshake; ready_q is only high in LEN/HI/LO/CHK
   assign xfer      = bus.byte_valid & ready_q;
   assign len_bad   = (bus.byte_in == 8'd0) || (32'(bus.byte_in) > DEPTH);
   // cnt_q doubles as the write address k and as words_loaded
   assign last_word = (32'(cnt_q) + 32'd1) == 32'(len_q);

   // Loader FSM; every output is a register updated with the transition.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         wsel_q   <= '0;
         data_q   <= '0;
         strobe_q <= 1'b0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
`ifdef CODE_LOADER_CHECKSUM_EN
         csum_q   <= '0;
`endif
      end else begin
         strobe_q <= 1'b0;
         unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.start) begin
                  state_q <= S_LEN;
                  len_q   <= '0;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b1;
`ifdef CODE_LOADER_CHECKSUM_EN
                  csum_q  <= '0;
`endif
               end
            end
            S_LEN: begin
               if (xfer) begin
                  len_q <= bus.byte_in;
`ifdef CODE_LOADER_CHECKSUM_EN
                  csum_q <= bus.byte_in;
`endif
                  if (len_bad) begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                     ready_q <= 1'b0;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= S_HI;
                  end
               end
            end
            S_HI: begin
               if (xfer) begin
                  data_q[15:8] <= bus.byte_in;
`ifdef CODE_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ bus.byte_in;
`endif
                  state_q <= S_LO;
               end
            end
            S_LO: begin
               // strobe and address go out together in the WR cycle
               if (xfer) begin
                  data_q[7:0] <= bus.byte_in;
`ifdef CODE_LOADER_CHECKSUM_EN
                  csum_q <= csum_q ^ bus.byte_in;
`endif
                  state_q  <= S_WR;
                  ready_q  <= 1'b0;
                  strobe_q <= 1'b1;
                  wsel_q   <= cnt_q[ADDR_W-1:0];
               end
            end
            S_WR: begin
               cnt_q <= cnt_q + CNT_W'(1);
               if (last_word) begin
`ifdef CODE_LOADER_CHECKSUM_EN
                  state_q <= S_CHK;
                  ready_q <= 1'b1;
`else
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
`endif
               end else begin
                  state_q <= S_HI;
                  ready_q <= 1'b1;
               end
            end
`ifdef CODE_LOADER_CHECKSUM_EN
            S_CHK: begin
               if (xfer) begin
                  ready_q <= 1'b0;
                  busy_q  <= 1'b0;
                  if (csum_q == bus.byte_in) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_ERR;
                     error_q <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.byte_ready   = ready_q;
   assign bus.write_select = wsel_q;
   assign bus.mem_data     = data_q;
   assign bus.mem_select   = strobe_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.error        = error_q;
   assign bus.words_loaded = cnt_q;

endmodule

// File: tb/tb_code_loader.sv
// ---------------------------------------------------------------------------
// tb_code_loader : scoreboard bench for code_loader. Expected writes are
// queued as images are driven and popped when mem_select is seen.
// Works with CODE_LOADER_CHECKSUM_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_code_loader;

   localparam int unsigned ADDR_W = 6;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [15:0]       data;
   } wr_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   code_loader_if #(.ADDR_W(ADDR_W)) bus ();

   code_loader #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          n_cmp    = 0;
   int          n_bad    = 0;
   int          wr_count = 0;
   wr_t         exp_q[$];
   wr_t         mon_e;
   logic [15:0] img[$];
   logic [15:0] mem_model[1 << ADDR_W];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // write monitor: every strobe must match the head of the scoreboard
   always @(negedge clk) begin
      if (rst_n && bus.mem_select === 1'b1) begin
         wr_count++;
         mem_model[bus.write_select] = bus.mem_data;
         check_eq("write_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            check_eq("wr_addr", 32'(bus.write_select), 32'(mon_e.addr));
            check_eq("wr_data", 32'(bus.mem_data), 32'(mon_e.data));
         end
      end
   end

   // all tasks are entered just after a rising edge
   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int gap;
      bit ok;
      ok  = 1'b0;
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      if (gap > 0) begin
         bus.byte_valid = 1'b0;
         repeat (gap) @(posedge clk);
         #1;
      end
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.byte_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         @(posedge clk);
         #1;
      end
      check_eq("byte_accept", 32'(ok), 32'd1);
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   // sends N, the words in img, and (if enabled) the checksum XOR flip
   task automatic load_image(input logic [7:0] n, input int gap, input logic [7:0] flip);
      logic [7:0] cs;
      cs = n;
      foreach (img[i]) exp_q.push_back(wr_t'{addr: ADDR_W'(i), data: img[i]});
      do_start();
      send_byte(n, gap);
      foreach (img[i]) begin
         send_byte(img[i][15:8], gap);
         send_byte(img[i][7:0], gap);
         cs = cs ^ img[i][15:8] ^ img[i][7:0];
      end
`ifdef CODE_LOADER_CHECKSUM_EN
      send_byte(cs ^ flip, gap);
`else
      cs = cs ^ flip;
`endif
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1 || bus.error === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_ready"}, 32'(bus.byte_ready), 32'd0);
      check_eq({tag, "_busy"},  32'(bus.busy), 32'd0);
      check_eq({tag, "_done"},  32'(bus.done), 32'd0);
      check_eq({tag, "_error"}, 32'(bus.error), 32'd0);
      check_eq({tag, "_words"}, 32'(bus.words_loaded), 32'd0);
      check_eq({tag, "_sel"},   32'(bus.mem_select), 32'd0);
      check_eq({tag, "_waddr"}, 32'(bus.write_select), 32'd0);
      check_eq({tag, "_wdata"}, 32'(bus.mem_data), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int wr0;
      logic [7:0] cs;
      bus.start      = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      rst_n          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // basic load, valid held high (also across the WR cycles)
      img = '{16'h1234, 16'hABCD};
      wr0 = wr_count;
      load_image(8'h02, 0, 8'h00);
      wait_end("basic_end");
      check_eq("basic_done",  32'(bus.done), 32'd1);
      check_eq("basic_error", 32'(bus.error), 32'd0);
      check_eq("basic_words", 32'(bus.words_loaded), 32'd2);
      check_eq("basic_busy",  32'(bus.busy), 32'd0);
      check_eq("basic_nwr",   32'(wr_count - wr0), 32'd2);
      check_eq("basic_sb",    32'(exp_q.size()), 32'd0);

      // extra byte after DONE is not consumed
      bus.byte_in    = 8'h55;
      bus.byte_valid = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("extra_ready", 32'(bus.byte_ready), 32'd0);
      check_eq("extra_done",  32'(bus.done), 32'd1);
      check_eq("extra_words", 32'(bus.words_loaded), 32'd2);
      bus.byte_valid = 1'b0;
      @(posedge clk);
      #1;

      // bad lengths: error on the next cycle, no write
      foreach (img[i]) img[i] = 16'h0;
      for (int t = 0; t < 2; t++) begin
         wr0 = wr_count;
         do_start();
         send_byte((t == 0) ? 8'h00 : 8'h41, 0);
         bus.byte_valid = 1'b0;
         @(negedge clk);
         check_eq("badlen_error", 32'(bus.error), 32'd1);
         check_eq("badlen_ready", 32'(bus.byte_ready), 32'd0);
         check_eq("badlen_busy",  32'(bus.busy), 32'd0);
         check_eq("badlen_done",  32'(bus.done), 32'd0);
         repeat (3) @(negedge clk);
         check_eq("badlen_nwr",   32'(wr_count - wr0), 32'd0);
         @(posedge clk);
         #1;
      end

      // full image: 64 words, addresses 0..63
      img.delete();
      for (int i = 0; i < 64; i++) img.push_back(16'h1000 + 16'(i));
      wr0 = wr_count;
      load_image(8'h40, 0, 8'h00);
      wait_end("full_end");
      check_eq("full_done",  32'(bus.done), 32'd1);
      check_eq("full_words", 32'(bus.words_loaded), 32'd64);
      check_eq("full_nwr",   32'(wr_count - wr0), 32'd64);
      check_eq("full_last",  32'(bus.write_select), 32'd63);
      check_eq("full_sb",    32'(exp_q.size()), 32'd0);

      // random stalls plus a start pulse mid-session
      wr0 = wr_count;
      exp_q.push_back(wr_t'{addr: ADDR_W'(0), data: 16'h1234});
      exp_q.push_back(wr_t'{addr: ADDR_W'(1), data: 16'hABCD});
      cs = 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'hAB ^ 8'hCD;
      do_start();
      send_byte(8'h02, 3);
      send_byte(8'h12, 3);
      bus.byte_valid = 1'b0;
      do_start();
      check_eq("midstart_busy",  32'(bus.busy), 32'd1);
      check_eq("midstart_words", 32'(bus.words_loaded), 32'd0);
      send_byte(8'h34, 3);
      send_byte(8'hAB, 3);
      send_byte(8'hCD, 3);
`ifdef CODE_LOADER_CHECKSUM_EN
      send_byte(cs, 3);
`endif
      bus.byte_valid = 1'b0;
      wait_end("stall_end");
      check_eq("stall_done",  32'(bus.done), 32'd1);
      check_eq("stall_words", 32'(bus.words_loaded), 32'd2);
      check_eq("stall_nwr",   32'(wr_count - wr0), 32'd2);

`ifdef CODE_LOADER_CHECKSUM_EN
      img = '{16'h1234};
      load_image(8'h01, 0, 8'h00);
      wait_end("csum_ok_end");
      check_eq("csum_ok_done",  32'(bus.done), 32'd1);
      check_eq("csum_ok_error", 32'(bus.error), 32'd0);
      load_image(8'h01, 0, 8'h0F);
      wait_end("csum_bad_end");
      check_eq("csum_bad_error", 32'(bus.error), 32'd1);
      check_eq("csum_bad_done",  32'(bus.done), 32'd0);
      check_eq("csum_bad_mem0",  32'(mem_model[0]), 32'h1234);
`endif

      // reset after the first word of a three-word image
      wr0 = wr_count;
      exp_q.push_back(wr_t'{addr: ADDR_W'(0), data: 16'h1111});
      do_start();
      send_byte(8'h03, 0);
      send_byte(8'h11, 0);
      send_byte(8'h11, 0);
      bus.byte_valid = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rstmid_nwr", 32'(wr_count - wr0), 32'd1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check_idle_outputs("rstmid");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      img = '{16'h2222};
      load_image(8'h01, 0, 8'h00);
      wait_end("reload_end");
      check_eq("reload_done",  32'(bus.done), 32'd1);
      check_eq("reload_words", 32'(bus.words_loaded), 32'd1);
      check_eq("reload_sb",    32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/code_loader.md
# code_loader

Program loader that fills the 64×16 code memory from an 8-bit byte stream, typically fed by the host-link receiver, before the CPU is released. It accepts a length-prefixed image and drives the memory write port: write address, write data and a one-cycle write strobe. It owns the write side of code memory during a load session; the CPU fetch path uses only the read side.

## Interface

- `ADDR_W`, default 6: code memory address width; depth is `1 << ADDR_W` words.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begins a load session. Sampled only in IDLE, DONE or ERR.
- `byte_in` in 8: stream data.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: loader can accept a byte. A byte transfers when `byte_valid & byte_ready`.
- `write_select` out `ADDR_W`: memory write address.
- `mem_data` out 16: memory write data.
- `mem_select` out 1: write strobe, one cycle per word.
- `busy` out 1: a session is in progress.
- `done` out 1: sticky; image loaded successfully.
- `error` out 1: sticky; the session was aborted.
- `words_loaded` out `ADDR_W+1`: count of words written this session.

## Operation

- States: IDLE, LEN, HI, LO, WR, CHK, DONE, ERR.
- IDLE/DONE/ERR + `start`:
  - go to LEN;
  - clear `done`, `error` and `words_loaded`;
  - clear the length register N and the address counter k.
- LEN: accept byte N.
  - N == 0 or N > `1 << ADDR_W`: go to ERR.
  - Otherwise go to HI.
- HI: accept the high byte into `mem_data[15:8]`; go to LO.
- LO: accept the low byte into `mem_data[7:0]`; go to WR.
- WR (exactly one cycle):
  - `mem_select` = 1, `write_select` = k;
  - k and `words_loaded` increment.
  - If `words_loaded` + 1 == N, go to CHK (macro on) or DONE (macro off). Otherwise go to HI.
- CHK: accept one byte (see Configuration).
- DONE: `done` = 1. ERR: `error` = 1. Both hold until the next `start` or reset.
- `byte_ready` = 1 only in LEN, HI, LO and CHK. It is 0 in IDLE, WR, DONE and ERR.
- `busy` = 1 in every state except IDLE, DONE and ERR.
- Byte order is big-endian: high byte first. Addresses run 0 .. N-1.
  - k never wraps; N = 64 ends exactly at address 63.
- `start` while `busy` is ignored.
- `byte_valid` while `byte_ready` = 0: the byte is not consumed and produces no error.
- `write_select` and `mem_data` hold their last values outside WR. `mem_select` is 0 outside WR.

## Timing

- Reset values: every output is 0 and the state is IDLE.
- Reset mid-session returns to IDLE next edge. Words already written stay in memory, but `words_loaded`, `done` and `error` clear.
- Low byte accepted at edge t: `mem_select` = 1 during cycle t→t+1. Next `byte_ready` = 1 from cycle t+1→t+2.
- Peak throughput: one word per 3 cycles with `byte_valid` held high.
- After the last WR (macro off): `done` = 1 and `busy` = 0 on the next cycle.
- Length error: `error` = 1 on the cycle after the LEN byte is accepted. No `mem_select` is ever asserted in that session.
- Gaps in `byte_valid` stall the FSM in place with no timeout.

## Configuration

- `CODE_LOADER_CHECKSUM_EN` defined:
  - The image carries a trailing checksum byte: XOR of N and all 2N data bytes.
  - The loader keeps a running XOR of every accepted byte.
  - In CHK: match → DONE, mismatch → ERR. Words already written stay in memory.
- `CODE_LOADER_CHECKSUM_EN` undefined:
  - The CHK state and the XOR register are removed.
  - WR for the last word goes directly to DONE.
  - Any extra byte is not consumed, because `byte_ready` = 0.

## Test plan

- Basic load (macro off): `start`, then bytes 02 12 34 AB CD.
  - Required: two `mem_select` pulses, addr0 = 1234 and addr1 = ABCD.
  - Required: `done` = 1, `words_loaded` = 2, `busy` = 0.
- Bad length: `start`, then N = 00. Repeat with N = 41h.
  - Required: `error` = 1 the next cycle, no `mem_select`, `byte_ready` = 0.
- Full image: N = 40h, word i = 1000h + i.
  - Required: 64 strobes at addresses 0..63 with no wrap, `words_loaded` = 64, `done` = 1.
- Stalls and ignored inputs:
  - Random `byte_valid` gaps → same writes as the basic load.
  - `start` pulsed mid-session → ignored.
  - `byte_valid` held during WR → no byte lost or duplicated.
- Checksum (macro on): N = 01, bytes 12 34, checksum 27 → `done` = 1.
  - Checksum 28 → `error` = 1, and addr0 still reads 1234.
- Reset mid-load: assert `rst_n` = 0 after the first word is written.
  - Required: all outputs 0, state IDLE. A new `start` reloads from address 0.
